mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_rr.sv | 35 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, requester count and address range helper.
// No timing or flow control of its own.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } mem_cmd_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned size);
        return addr < size;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant selection with a registered priority pointer.
// Grant is combinational from req; pointer moves on the edge when advance is high.
// No backpressure: the caller decides when a grant is taken via advance.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               gnt_vld,
    output logic               gnt_idx
);

    logic ptr_q;

    // Under contention the pointer decides; a lone requester always wins.
    always_comb begin
        gnt_vld = |req;
        if (&req) begin
            gnt_idx = ptr_q;
        end else begin
            gnt_idx = req[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else if (advance && gnt_vld) begin
            ptr_q <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port memory, one access at a time.
// Request sampled in IDLE -> ack two cycles later; grants spaced three cycles apart.
// Requesters hold req until ack; the memory is assumed always ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_memW,
    output logic              mem_memR,
    input  logic [DATA_W-1:0] mem_readData
);

    arb_state_t        state_q;
    logic              gnt_vld;
    logic              gnt_idx;
    mem_cmd_t          gnt_cmd;
    logic [DATA_W-1:0] gnt_wdata;
    logic              gnt_in_range;

    logic              sel_q;
    logic              we_q;
    logic              oor_q;
    logic [DATA_W-1:0] rdata_nxt;

    mem_arb_rr u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1, req0}),
        .advance (state_q == IDLE),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        gnt_cmd      = gnt_idx ? {we1, addr1} : {we0, addr0};
        gnt_wdata    = gnt_idx ? wdata1 : wdata0;
        gnt_in_range = addr_in_range(gnt_cmd.addr, SIZE);
        rdata_nxt    = oor_q ? '0 : mem_readData;
    end

    // Memory strobes are registers on the async reset, so they fall the moment reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_memW    <= 1'b0;
            mem_memR    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        sel_q   <= gnt_idx;
                        we_q    <= gnt_cmd.we;
                        oor_q   <= ~gnt_in_range;
                        if (gnt_in_range) begin
                            mem_address <= gnt_cmd.addr;
                            mem_data    <= gnt_wdata;
                            mem_memW    <= gnt_cmd.we;
                            mem_memR    <= ~gnt_cmd.we;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_address <= '0;
                    mem_data    <= '0;
                    mem_memW    <= 1'b0;
                    mem_memR    <= 1'b0;
                    // Writes leave rdata alone unless the address was bad.
                    if (oor_q || !we_q) begin
                        if (sel_q) begin
                            rdata1 <= rdata_nxt;
                        end else begin
                            rdata0 <= rdata_nxt;
                        end
                    end
                    ack0    <= ~sel_q;
                    ack1    <= sel_q;
                    err0    <= ~sel_q & oor_q;
                    err1    <= sel_q & oor_q;
                    state_q <= RESPOND;
                end
                RESPOND: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    err0    <= 1'b0;
                    err1    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a transaction-level model predicts
// grant order, memory strobes and acks; a negedge monitor compares against the DUT.
module tb_mem_arbiter;

    localparam int SIZE = 32;
    localparam int DW   = 32;
    localparam int AW   = $clog2(SIZE);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0, req1, we0, we1;
    logic [31:0]   addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic [31:0]   mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_memW, mem_memR;
    logic [DW-1:0] mem_readData;

    always #5 clk = ~clk;

    mem_arbiter #(.SIZE(SIZE), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack0         (ack0),
        .ack1         (ack1),
        .err0         (err0),
        .err1         (err1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_memW     (mem_memW),
        .mem_memR     (mem_memR),
        .mem_readData (mem_readData)
    );

    // Requester-side drive state
    logic [1:0]    rq = '0;
    logic [1:0]    rwe = '0;
    logic [31:0]   raddr [2];
    logic [DW-1:0] rwd [2];
    assign req0 = rq[0];
    assign req1 = rq[1];
    assign we0 = rwe[0];
    assign we1 = rwe[1];
    assign addr0 = raddr[0];
    assign addr1 = raddr[1];
    assign wdata0 = rwd[0];
    assign wdata1 = rwd[1];

    // Attached memory (environment, driven by the DUT)
    logic          mem_init = 1'b1;
    logic [DW-1:0] mem_arr [SIZE];

    function automatic logic [DW-1:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < SIZE; i++) mem_arr[i] <= init_word(i);
        end else if (mem_memW && mem_address < 32'(SIZE)) begin
            mem_arr[mem_address[AW-1:0]] <= mem_data;
        end
    end
    assign mem_readData = (mem_address < 32'(SIZE)) ? mem_arr[mem_address[AW-1:0]] : 32'hBAD0_BAD0;

    // Reference model: the arbiter is free every third cycle after a grant
    typedef struct { int cyc; logic err; logic [DW-1:0] rdata; } ack_exp_t;
    typedef struct { int cyc; logic we; logic [31:0] addr; logic [DW-1:0] data; } mem_exp_t;

    ack_exp_t      ackq [2][$];
    mem_exp_t      memq [$];
    logic [DW-1:0] ref_mem [SIZE];
    logic [DW-1:0] last_rd [2];
    int            cyc = 0;
    int            free_cyc = 0;
    int            ptr = 0;
    logic          pw_vld = 1'b0;
    int            pw_cyc = 0;
    logic [AW-1:0] pw_addr = '0;
    logic [DW-1:0] pw_data = '0;

    int            checks = 0;
    int            fails = 0;
    int            ack_cnt [2];
    int            ack_used [2];
    int            wait_cnt [2];
    logic          rst_stage = 1'b0;
    logic          rand_mode = 1'b0;
    logic [1:0]    stg_vld = '0, stg_drop = '0, stg_we = '0;
    logic [31:0]   stg_addr [2];
    logic [DW-1:0] stg_data [2];

    task automatic model_eval();
        int g;
        logic inr;
        if (pw_vld && cyc > pw_cyc) begin
            ref_mem[pw_addr] = pw_data;
            pw_vld = 1'b0;
        end
        if (!reset) begin
            ackq[0].delete();
            ackq[1].delete();
            memq.delete();
            pw_vld = 1'b0;
            ptr = 0;
            last_rd[0] = '0;
            last_rd[1] = '0;
            free_cyc = cyc + 1;
            return;
        end
        if (cyc != free_cyc) return;
        if (rq == 2'b00) begin
            free_cyc = cyc + 1;
            return;
        end
        g = (rq == 2'b11) ? ptr : (rq[0] ? 0 : 1);
        ptr = 1 - g;
        free_cyc = cyc + 3;
        inr = raddr[g] < 32'(SIZE);
        if (!inr) last_rd[g] = '0;
        else if (!rwe[g]) last_rd[g] = ref_mem[raddr[g][AW-1:0]];
        ackq[g].push_back('{cyc + 2, !inr, last_rd[g]});
        if (inr) begin
            memq.push_back('{cyc + 1, rwe[g], raddr[g], rwd[g]});
            if (rwe[g]) begin
                pw_vld = 1'b1;
                pw_cyc = cyc + 1;
                pw_addr = raddr[g][AW-1:0];
                pw_data = rwd[g];
            end
        end
    endtask

    task automatic rand_addr(output logic [31:0] a);
        int r = $urandom_range(0, 9);
        if (r < 8) a = 32'($urandom_range(0, SIZE - 1));
        else if (r == 8) a = 32'(SIZE + $urandom_range(0, 7));
        else a = $urandom;
    endtask

    task automatic random_update();
        for (int i = 0; i < 2; i++) begin
            if (rq[i]) begin
                if ($urandom_range(0, 19) == 0) begin
                    rq[i] = 1'b0;
                    wait_cnt[i] = 3;
                    raddr[i] = $urandom;
                    rwd[i] = $urandom;
                end
            end else if (wait_cnt[i] > 0) begin
                wait_cnt[i]--;
            end else if ($urandom_range(0, 2) != 0) begin
                rq[i] = 1'b1;
                rwe[i] = 1'($urandom_range(0, 1));
                rand_addr(raddr[i]);
                rwd[i] = $urandom;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        reset = rst_stage;
        if (!reset) rq = '0;
        for (int i = 0; i < 2; i++) begin
            if (ack_cnt[i] != ack_used[i]) begin
                ack_used[i] = ack_cnt[i];
                rq[i] = 1'b0;
                wait_cnt[i] = $urandom_range(0, 2);
                raddr[i] = $urandom;
                rwd[i] = $urandom;
            end
        end
        if (rand_mode) random_update();
        for (int i = 0; i < 2; i++) begin
            if (stg_vld[i]) begin
                rq[i] = 1'b1;
                rwe[i] = stg_we[i];
                raddr[i] = stg_addr[i];
                rwd[i] = stg_data[i];
            end
            if (stg_drop[i]) begin
                rq[i] = 1'b0;
                raddr[i] = $urandom;
                rwd[i] = $urandom;
            end
        end
        stg_vld = '0;
        stg_drop = '0;
        model_eval();
    endtask

    task automatic stage(input int i, input logic we, input logic [31:0] a, input logic [DW-1:0] d);
        stg_vld[i] = 1'b1;
        stg_we[i] = we;
        stg_addr[i] = a;
        stg_data[i] = d;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rq != 0 || ackq[0].size() != 0 || ackq[1].size() != 0 || memq.size() != 0) begin
            cycle();
            n++;
            if (n > 40) begin
                $display("FAIL wait_idle: still outstanding after %0d cycles, req=%b required=00", n, rq);
                $fatal(1, "bench timeout");
            end
        end
    endtask

    task automatic fail_msg(input string s);
        fails++;
        $display("FAIL %s", s);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [1:0]    ack_v, err_v;
        logic [DW-1:0] rd_v [2];
        ack_exp_t      e;
        mem_exp_t      m;
        ack_v = {ack1, ack0};
        err_v = {err1, err0};
        rd_v[0] = rdata0;
        rd_v[1] = rdata1;
        if (!reset) begin
            checks++;
            if ({ack_v, err_v, mem_memR, mem_memW} != 0 || rdata0 != 0 || rdata1 != 0 ||
                mem_address != 0 || mem_data != 0)
                fail_msg($sformatf("reset_state cyc=%0d: ack=%b err=%b R=%b W=%b rd0=%h rd1=%h addr=%h data=%h, required all zero",
                         cyc, ack_v, err_v, mem_memR, mem_memW, rdata0, rdata1, mem_address, mem_data));
        end else begin
            checks++;
            if (mem_memR && mem_memW)
                fail_msg($sformatf("strobe_excl cyc=%0d: R=1 W=1, required at most one", cyc));
            checks++;
            if (mem_memR || mem_memW) begin
                if (memq.size() == 0 || memq[0].cyc != cyc) begin
                    fail_msg($sformatf("mem_strobe cyc=%0d: got R=%b W=%b addr=%h, required no strobe", cyc, mem_memR, mem_memW, mem_address));
                    if (memq.size() != 0 && memq[0].cyc < cyc) void'(memq.pop_front());
                end else begin
                    m = memq.pop_front();
                    if (mem_memW !== m.we || mem_memR !== !m.we || mem_address !== m.addr || mem_data !== m.data)
                        fail_msg($sformatf("mem_access cyc=%0d: got W=%b addr=%h data=%h, required W=%b addr=%h data=%h",
                                 cyc, mem_memW, mem_address, mem_data, m.we, m.addr, m.data));
                end
            end else begin
                if (mem_address != 0 || mem_data != 0)
                    fail_msg($sformatf("mem_idle_bus cyc=%0d: got addr=%h data=%h, required 0", cyc, mem_address, mem_data));
                else if (memq.size() != 0 && memq[0].cyc <= cyc) begin
                    m = memq.pop_front();
                    fail_msg($sformatf("mem_missing cyc=%0d: got no strobe, required W=%b addr=%h", cyc, m.we, m.addr));
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ack_v[i]) begin
                    ack_cnt[i]++;
                    if (ackq[i].size() == 0 || ackq[i][0].cyc != cyc) begin
                        fail_msg($sformatf("ack%0d cyc=%0d: got unexpected ack=1, required ack=0", i, cyc));
                        if (ackq[i].size() != 0 && ackq[i][0].cyc < cyc) void'(ackq[i].pop_front());
                    end else begin
                        e = ackq[i].pop_front();
                        if (err_v[i] !== e.err || rd_v[i] !== e.rdata)
                            fail_msg($sformatf("resp%0d cyc=%0d: got err=%b rdata=%h, required err=%b rdata=%h",
                                     i, cyc, err_v[i], rd_v[i], e.err, e.rdata));
                    end
                end else if (err_v[i]) begin
                    fail_msg($sformatf("err%0d cyc=%0d: got err=1 without ack, required 0", i, cyc));
                end else if (ackq[i].size() != 0 && ackq[i][0].cyc <= cyc) begin
                    e = ackq[i].pop_front();
                    fail_msg($sformatf("ack%0d_missing cyc=%0d: got ack=0, required ack=1 at cyc %0d", i, cyc, e.cyc));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < SIZE; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 2; i++) begin
            ack_cnt[i] = 0; ack_used[i] = 0; wait_cnt[i] = 0; last_rd[i] = '0;
            raddr[i] = '0; rwd[i] = '0; stg_addr[i] = '0; stg_data[i] = '0;
        end
        #1 reset = 1'b0;
        repeat (3) cycle();
        mem_init = 1'b0;

        // Contention straight out of reset: write by 0, then read of same word by 1
        rst_stage = 1'b1;
        stage(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        stage(1, 1'b0, 32'd5, 32'h1111_2222);
        cycle();
        wait_idle();
        stage(0, 1'b0, 32'd5, 32'h0BAD_F00D);
        cycle(); wait_idle();
        stage(1, 1'b0, 32'd32, 32'h3333_4444);
        cycle(); wait_idle();
        stage(1, 1'b1, 32'd40, 32'h5555_6666);
        cycle(); wait_idle();
        repeat (4) begin
            stage(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, SIZE - 1)), $urandom);
            stage(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, SIZE - 1)), $urandom);
            cycle(); wait_idle();
        end

        // Drop after grant still completes; drop before grant is ignored
        stage(1, 1'b1, 32'd7, 32'hCAFE_F00D);
        cycle();
        stg_drop[1] = 1'b1;
        cycle(); wait_idle();
        stage(1, 1'b0, 32'd7, 32'h0);
        cycle(); wait_idle();
        stage(0, 1'b0, 32'd3, 32'h0);
        cycle();
        stage(1, 1'b0, 32'd4, 32'h0);
        cycle();
        stg_drop[1] = 1'b1;
        cycle(); wait_idle();

        // Reset during the ACCESS cycle of a write, then contention to probe the pointer
        stage(0, 1'b1, 32'd9, 32'h5555_AAAA);
        cycle();
        rst_stage = 1'b0;
        repeat (3) cycle();
        rst_stage = 1'b1;
        stage(0, 1'b0, 32'd9, 32'h0);
        stage(1, 1'b0, 32'd9, 32'h0);
        cycle(); wait_idle();

        rand_mode = 1'b1;
        repeat (1000) cycle();
        rand_mode = 1'b0;
        wait_idle();
        repeat (3) cycle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
